// File: rtl/fpga_rst_seq.sv
// Multi-domain reset sequencer: filters PLL lock, releases domain
// resets in index order and handles ndmreset and lock loss.
module fpga_rst_seq #(
  parameter int unsigned NrDomains        = 2,
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned LockFilterCycles = 1024,
  parameter int unsigned StageDelay       = 16,
  parameter logic [NrDomains-1:0] NdmMask = NrDomains'(2'b10)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pll_locked_i,
  input  logic                 ndmreset_i,
  output logic [NrDomains-1:0] rst_no,
  output logic [1:0]           state_o,
  output logic                 locked_o,
  output logic [7:0]           lock_loss_cnt_o
);

  localparam int unsigned FW = $clog2(LockFilterCycles + 1);
  localparam int unsigned SW = $clog2(StageDelay + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    NDM       = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [SyncStages-1:0] sync_q, sync_d;
  logic [FW-1:0]         filt_q, filt_d;
  logic [SW-1:0]         stg_q, stg_d;
  logic [NrDomains-1:0]  rst_q, rst_d;
  logic                  locked_q, locked_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [NrDomains-1:0]  rel_oh;
  logic                  lk;

  assign lk = sync_q[SyncStages-1];

  // Lock synchroniser shift chain
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pll_locked_i};
  end

  // One-hot of the lowest-index domain still held in reset
  always_comb begin
    rel_oh = '0;
    for (int k = int'(NrDomains) - 1; k >= 0; k--) begin
      if (!rst_q[k]) begin
        rel_oh    = '0;
        rel_oh[k] = 1'b1;
      end
    end
  end

  // Next-state and output logic; lock loss outranks ndmreset
  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    stg_d    = stg_q;
    rst_d    = rst_q;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    if (state_q == WAIT_LOCK) begin
      rst_d = '0;
      if (!lk) begin
        filt_d = '0;
      end else if (filt_q == FW'(LockFilterCycles - 1)) begin
        filt_d   = '0;
        state_d  = RELEASE;
        locked_d = 1'b1;
        stg_d    = '0;
      end else begin
        filt_d = filt_q + 1'b1;
      end
    end else if (!lk) begin
      state_d  = WAIT_LOCK;
      rst_d    = '0;
      locked_d = 1'b0;
      filt_d   = '0;
      stg_d    = '0;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        RELEASE: begin
          if (ndmreset_i) begin
            rst_d   = rst_q & ~NdmMask;
            state_d = NDM;
          end else if (&rst_q) begin
            state_d = RUN;
          end else if (stg_q == SW'(StageDelay - 1)) begin
            stg_d = '0;
            rst_d = rst_q | rel_oh;
            if (&(rst_q | rel_oh)) begin
              state_d = RUN;
            end
          end else begin
            stg_d = stg_q + 1'b1;
          end
        end
        RUN: begin
          if (ndmreset_i) begin
            rst_d   = rst_q & ~NdmMask;
            state_d = NDM;
          end
        end
        NDM: begin
          if (!ndmreset_i) begin
            state_d = RELEASE;
            stg_d   = '0;
          end
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WAIT_LOCK;
      sync_q   <= '0;
      filt_q   <= '0;
      stg_q    <= '0;
      rst_q    <= '0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      stg_q    <= stg_d;
      rst_q    <= rst_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rst_no          = rst_q;
  assign state_o         = state_q;
  assign locked_o        = locked_q;
  assign lock_loss_cnt_o = cnt_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Bench for fpga_rst_seq: directed scenarios plus random lock and
// ndmreset traffic checked against a release-schedule model.
module tb_fpga_rst_seq;

  localparam int S = 2;
  localparam int F = 8;
  localparam int D = 4;
  localparam int N = 2;
  localparam logic [1:0] MASK = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll = 1'b0;
  logic       ndm = 1'b0;
  logic [1:0] rst_no;
  logic [1:0] state_o;
  logic       locked_o;
  logic [7:0] cnt_o;

  int n_cmp = 0;
  int n_fail = 0;

  fpga_rst_seq #(
    .NrDomains(N), .SyncStages(S), .LockFilterCycles(F),
    .StageDelay(D), .NdmMask(MASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(pll),
    .ndmreset_i(ndm), .rst_no(rst_no), .state_o(state_o),
    .locked_o(locked_o), .lock_loss_cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: lock seen S edges late, release schedule by
  // position in the list of held domains.
  bit         q_sync[$];
  int         m_run;
  logic       m_locked;
  logic [1:0] m_mode;
  logic [1:0] m_rst;
  logic [7:0] m_loss;
  int         m_t;
  int         pend[$];

  task automatic model_reset();
    q_sync.delete();
    for (int i = 0; i < S; i++) q_sync.push_back(1'b0);
    m_run = 0; m_locked = 0; m_mode = 0; m_rst = '0;
    m_loss = '0; m_t = 0; pend.delete();
  endtask

  task automatic model_edge(input bit p, input bit n);
    bit lk;
    lk = q_sync.pop_front();
    q_sync.push_back(p);
    if (m_mode == 0) begin
      m_run = lk ? m_run + 1 : 0;
      if (m_run == F) begin
        m_mode = 1; m_locked = 1; m_t = 0; pend.delete();
        for (int k = 0; k < N; k++) pend.push_back(k);
      end
    end else if (!lk) begin
      m_mode = 0; m_locked = 0; m_rst = '0; m_run = 0;
      if (m_loss != 8'hFF) m_loss = m_loss + 8'd1;
    end else if (m_mode == 3) begin
      if (!n) begin
        m_mode = 1; m_t = 0; pend.delete();
        for (int k = 0; k < N; k++) if (!m_rst[k]) pend.push_back(k);
      end
    end else if (n) begin
      m_rst = m_rst & ~MASK;
      m_mode = 3;
    end else if (m_mode == 1) begin
      if (pend.size() == 0) begin
        m_mode = 2;
      end else begin
        m_t++;
        if (m_t % D == 0) begin
          m_rst[pend.pop_front()] = 1'b1;
          if (pend.size() == 0) m_mode = 2;
        end
      end
    end
  endtask

  task automatic drive(input bit p, input bit n);
    pll = p; ndm = n;
    @(posedge clk);
    model_edge(p, n);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll = 1'b0; ndm = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({rst_no, state_o, locked_o, cnt_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset: got rst=%b st=%0d lk=%b cnt=%0d want all 0",
               rst_no, state_o, locked_o, cnt_o);
    end
  endtask

  task automatic test_powerup();
    int r0 = 0, r1 = 0;
    logic [1:0] st18 = '0;
    for (int e = 1; e <= 20; e++) begin
      drive(1, 0);
      n_cmp++;
      if ({rst_no, state_o, locked_o, cnt_o} !==
          {m_rst, m_mode, m_locked, m_loss}) begin
        n_fail++;
        $display("FAIL powerup e%0d: got %b/%0d/%b/%0d want %b/%0d/%b/%0d",
                 e, rst_no, state_o, locked_o, cnt_o,
                 m_rst, m_mode, m_locked, m_loss);
      end
      if (rst_no[0] && r0 == 0) r0 = e;
      if (rst_no[1] && r1 == 0) r1 = e;
      if (e == 18) st18 = state_o;
    end
    n_cmp++;
    if (r0 !== 14) begin
      n_fail++; $display("FAIL powerup_rise0: edge %0d want 14", r0);
    end
    n_cmp++;
    if (r1 !== 18) begin
      n_fail++; $display("FAIL powerup_rise1: edge %0d want 18", r1);
    end
    n_cmp++;
    if (st18 !== 2'd2) begin
      n_fail++; $display("FAIL powerup_run: state %0d want 2", st18);
    end
  endtask

  task automatic test_filter();
    int r0 = 0;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      drive(!(e == 6), 0);
      n_cmp++;
      if ({rst_no, state_o, locked_o, cnt_o} !==
          {m_rst, m_mode, m_locked, m_loss}) begin
        n_fail++;
        $display("FAIL filter e%0d: got %b/%0d/%b/%0d want %b/%0d/%b/%0d",
                 e, rst_no, state_o, locked_o, cnt_o,
                 m_rst, m_mode, m_locked, m_loss);
      end
      if (rst_no[0] && r0 == 0) r0 = e;
    end
    n_cmp++;
    if (r0 !== 20) begin
      n_fail++; $display("FAIL filter_rise0: edge %0d want 20", r0);
    end
    n_cmp++;
    if (cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL filter_cnt: got %0d want 0", cnt_o);
    end
  endtask

  task automatic test_ndm();
    bit dropped0 = 0;
    int r1 = 0;
    for (int e = 1; e <= 10; e++) begin
      drive(1, 1);
      if (e == 1) begin
        n_cmp++;
        if (rst_no !== 2'b01 || state_o !== 2'd3) begin
          n_fail++;
          $display("FAIL ndm_entry: got rst=%b st=%0d want 01/3",
                   rst_no, state_o);
        end
      end
      if (!rst_no[0]) dropped0 = 1;
    end
    for (int j = 0; j < 10; j++) begin
      drive(1, 0);
      n_cmp++;
      if ({rst_no, state_o, locked_o, cnt_o} !==
          {m_rst, m_mode, m_locked, m_loss}) begin
        n_fail++;
        $display("FAIL ndm j%0d: got %b/%0d/%b/%0d want %b/%0d/%b/%0d",
                 j, rst_no, state_o, locked_o, cnt_o,
                 m_rst, m_mode, m_locked, m_loss);
      end
      if (!rst_no[0]) dropped0 = 1;
      if (rst_no[1] && r1 == 0) r1 = j;
    end
    n_cmp++;
    if (dropped0) begin
      n_fail++; $display("FAIL ndm_dom0: got dropped want held high");
    end
    n_cmp++;
    if (r1 !== 4) begin
      n_fail++; $display("FAIL ndm_rerelease: edge +%0d want +4", r1);
    end
  endtask

  task automatic test_lock_loss();
    int z = 0, r0 = 0, r1 = 0;
    for (int e = 1; e <= 4; e++) begin
      drive(0, 0);
      if (rst_no == 2'b00 && z == 0) z = e;
    end
    n_cmp++;
    if (z !== S + 1) begin
      n_fail++; $display("FAIL loss_edge: edge %0d want %0d", z, S + 1);
    end
    n_cmp++;
    if (cnt_o !== 8'd1 || locked_o !== 1'b0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL loss_state: got cnt=%0d lk=%b st=%0d want 1/0/0",
               cnt_o, locked_o, state_o);
    end
    for (int e = 1; e <= 20; e++) begin
      drive(1, 0);
      n_cmp++;
      if ({rst_no, state_o, locked_o, cnt_o} !==
          {m_rst, m_mode, m_locked, m_loss}) begin
        n_fail++;
        $display("FAIL relock e%0d: got %b/%0d/%b/%0d want %b/%0d/%b/%0d",
                 e, rst_no, state_o, locked_o, cnt_o,
                 m_rst, m_mode, m_locked, m_loss);
      end
      if (rst_no[0] && r0 == 0) r0 = e;
      if (rst_no[1] && r1 == 0) r1 = e;
    end
    n_cmp++;
    if (r0 !== 14 || r1 !== 18) begin
      n_fail++; $display("FAIL relock_rise: got %0d/%0d want 14/18", r0, r1);
    end
  endtask

  task automatic test_loss_ndm_same();
    drive(0, 0);
    drive(0, 0);
    drive(0, 1);
    n_cmp++;
    if (state_o !== 2'd0 || rst_no !== 2'b00) begin
      n_fail++;
      $display("FAIL loss_vs_ndm: got st=%0d rst=%b want 0/00",
               state_o, rst_no);
    end
    drive(0, 0);
    for (int i = 0; i < 256; i++) begin
      for (int e = 0; e < 13; e++) begin
        drive(e < S + F, 0);
        n_cmp++;
        if ({rst_no, state_o, locked_o, cnt_o} !==
            {m_rst, m_mode, m_locked, m_loss}) begin
          n_fail++;
          $display("FAIL sat i%0d e%0d: got %b/%0d/%b/%0d want %b/%0d/%b/%0d",
                   i, e, rst_no, state_o, locked_o, cnt_o,
                   m_rst, m_mode, m_locked, m_loss);
        end
      end
    end
    n_cmp++;
    if (cnt_o !== 8'hFF) begin
      n_fail++; $display("FAIL sat_cnt: got %0d want 255", cnt_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int e = 1; e <= 15; e++) drive(1, 0);
    n_cmp++;
    if (rst_no !== 2'b01 || state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL async_pre: got rst=%b st=%0d want 01/1", rst_no, state_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rst_no, state_o, locked_o, cnt_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_rst: got rst=%b st=%0d lk=%b cnt=%0d want all 0",
               rst_no, state_o, locked_o, cnt_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit n = 0;
    do_reset();
    for (int e = 0; e < 1500; e++) begin
      if ($urandom_range(0, 99) < 6) n = !n;
      drive($urandom_range(0, 99) < 97, n);
      n_cmp++;
      if ({rst_no, state_o, locked_o, cnt_o} !==
          {m_rst, m_mode, m_locked, m_loss}) begin
        n_fail++;
        $display("FAIL random e%0d: got %b/%0d/%b/%0d want %b/%0d/%b/%0d",
                 e, rst_no, state_o, locked_o, cnt_o,
                 m_rst, m_mode, m_locked, m_loss);
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_filter();
    test_ndm();
    test_lock_loss();
    test_loss_ndm_same();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
